// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset PC and fetch FSM encoding.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 32;
  localparam logic [7:0] RESET_PC = 8'h00;
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t IDLE = 2'd0;
  localparam fetch_state_t RUN = 2'd1;
  localparam fetch_state_t HALTED = 2'd2;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: small FIFO of {pc, instr}; flush beats push, head reads zero when empty.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = empty ? '0 : mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else begin
      if (push) mem_d[wr_q] = din;
      wr_d = push ? wr_q + 1'b1 : wr_q;
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer feeding a fetch buffer to decode, with redirect and halt.
// Defining FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc,
  input  logic               halt_req,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);
  cpu_pkg::fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic full, empty, push, pop, redir, run_ok;
  logic [ADDR_W+INSTR_W-1:0] head;
  assign imem_addr = pc_q;
  assign out_valid = !empty;
  assign {out_pc, out_instr} = head;
  assign halted = state_q == cpu_pkg::HALTED;
  assign pop = out_valid && out_ready;
  assign redir = redir_valid && state_q != cpu_pkg::IDLE;
  assign run_ok = state_q == cpu_pkg::RUN && !halt_req && !redir_valid;
  assign push = run_ok && (!full || pop);
  always_comb begin
    pc_d = redir ? redir_pc : push ? pc_q + 1'b1 : pc_q;
    state_d = (state_q == cpu_pkg::IDLE && en) || (state_q == cpu_pkg::HALTED && redir_valid) ? cpu_pkg::RUN :
              (state_q == cpu_pkg::RUN && halt_req) ? cpu_pkg::HALTED : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= cpu_pkg::IDLE;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  fetch_buf #(.DEPTH(BUF_DEPTH), .W(ADDR_W + INSTR_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redir),
    .din({pc_q, imem_instr}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d, stall_q, stall_d;
  assign perf_fetched = fetched_q;
  assign perf_stall = stall_q;
  always_comb begin
    fetched_d = fetched_q + 32'(push);
    stall_d = stall_q + 32'(run_ok && full && !pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q <= stall_d;
    end
  end
`endif
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer in front of `instruction_memory`. It owns the program counter, drives the memory's 8-bit word address, and captures each returned 32-bit instruction with its PC into a small fetch buffer. Decode drains the buffer through a valid/ready handshake. Execute can redirect fetch on a branch, and a halt request stops fetch.

## Interface
- `ADDR_W`, 8: PC / memory word-address width.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 0: PC loaded at reset.
- `BUF_DEPTH`, 2: fetch buffer entries; power of two, ≥2.
- `clk` in 1: single clock; all state on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: start fetching; sampled only in IDLE.
- `imem_addr` out ADDR_W: address to `instruction_memory`; the memory is combinational, so data is valid in the same cycle.
- `imem_instr` in INSTR_W: instruction returned for `imem_addr`.
- `out_valid` out 1: buffer head is valid.
- `out_ready` in 1: decode accepts the head.
- `out_instr` out INSTR_W: head instruction.
- `out_pc` out ADDR_W: PC of the head instruction.
- `redir_valid` in 1: branch redirect, one-cycle pulse.
- `redir_pc` in ADDR_W: redirect target.
- `halt_req` in 1: stop fetching.
- `halted` out 1: high in HALTED state.

## Operation
- FSM states: IDLE, RUN, HALTED.
  - IDLE → RUN when `en`=1.
  - RUN → HALTED when `halt_req`=1.
  - HALTED → RUN on `redir_valid`.
  - `halt_req` has no effect outside RUN.
- `imem_addr` = `fetch_pc` at all times.
- Push occurs in a cycle when all of these hold:
  - state is RUN;
  - `halt_req`=0;
  - `redir_valid`=0;
  - buffer not full, or full with a pop in the same cycle.
- On push: write {`fetch_pc`, `imem_instr`} at the tail, then `fetch_pc` ← `fetch_pc`+1, modulo 2^ADDR_W (255 wraps to 0).
- Pop: `out_valid` && `out_ready`; head advances.
- Redirect (any state except IDLE; ignored in IDLE):
  - flush all buffer entries, including the one being popped;
  - `fetch_pc` ← `redir_pc`;
  - no push that cycle;
  - from HALTED, go to RUN.
- Redirect and `halt_req` in the same cycle: the redirect applies (flush, load PC), then the FSM enters HALTED with `fetch_pc`=`redir_pc`.
- HALTED: no pushes. The buffer keeps draining to decode.
- Buffer occupancy counter runs from 0 to BUF_DEPTH. Pointers are log2(BUF_DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - `fetch_pc`=RESET_PC, so `imem_addr`=RESET_PC;
  - state IDLE;
  - count 0;
  - `out_valid`=0;
  - `out_instr`=0 and `out_pc`=0 (registered head reads zero when empty);
  - `halted`=0.
- Latency:
  - `en` sampled in cycle N → RUN in N+1 → first push in N+1 → `out_valid`=1 in N+2;
  - redirect in cycle R → first push from target in R+1 → `out_valid` in R+2.
- Steady state: with `out_ready` held high, one instruction per cycle.
- `out_valid`, `out_instr` and `out_pc` are stable while `out_valid`=1 and `out_ready`=0.
- An asynchronous reset mid-operation drops all buffered entries and immediately returns every output to its reset value.

## Configuration
- `FETCH_PERF_EN` defined adds two extra outputs:
  - `perf_fetched` (32 bits): counts pushes;
  - `perf_stall` (32 bits): counts RUN cycles with no push because the buffer is full.
  - Both reset to 0, wrap at 2^32, and are not cleared by a redirect.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist. Functional behaviour is identical either way.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W` and `INSTR_W` defaults;
  - FSM state encoding `fetch_state_t` (IDLE=0, RUN=1, HALTED=2);
  - `RESET_PC` constant.
- One sub-module, `fetch_buf`:
  - parameterised FIFO holding {pc, instr};
  - push/pop/flush inputs, full/empty outputs;
  - flush has priority over push.
- `fetch_unit` holds the FSM, the PC and the push/pop control.

## Test plan
- Reset and start:
  - memory holds 0x11111111, 0x22222222, … at 0, 1, …;
  - assert `en` with `out_ready`=1;
  - expect `out_valid` two cycles after `en`, with pairs (pc 0, 0x11111111), (1, 0x22222222), (2, 0x33333333) on consecutive cycles.
- Back-pressure:
  - hold `out_ready`=0 for 5 cycles;
  - expect `imem_addr` to freeze at 2 once the buffer is full, the head to stay (0, 0x11111111), and `perf_stall`=3 (if `FETCH_PERF_EN` is defined);
  - release `out_ready` and expect PCs 0, 1, 2 in order with no gaps or duplicates.
- Redirect:
  - while PCs 4 and 5 are buffered, pulse `redir_valid` with `redir_pc`=0x40;
  - expect the next `out_valid` two cycles later with `out_pc`=0x40, and PCs 4 and 5 never seen.
- Wrap-around:
  - redirect to 0xFE;
  - expect the PC sequence 0xFE, 0xFF, 0x00, 0x01.
- Halt and resume:
  - assert `halt_req` with 2 entries buffered;
  - expect `halted`=1 next cycle, both entries drained, then `out_valid`=0;
  - redirect to 0x10 and expect RUN, then `out_pc`=0x10.
- Mid-run reset:
  - drop `rst_n` asynchronously with the buffer full;
  - expect `out_valid`=0, `imem_addr`=RESET_PC and `halted`=0 before the next clock edge.
